load_store_unit: RTL

CPU-side initiator for the data-memory port. Accepts one load or store at a time from the execute stage, checks alignment, and drives a word-aligned request with byte mask and lane-shifted write data to the data memory. It then waits for read data, and returns the extracted, sign- or zero-extended load result. It sits between the core pipeline and the data memory, and owns all lane/offset handling so the memory sees only word requests.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_load_extract.sv | 27 ++
 rtl/load_store_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - Shared memOp encodings, FSM states and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd4;
  localparam logic [2:0] M_LHU = 3'd5;
  localparam logic [2:0] M_SB  = M_LB;
  localparam logic [2:0] M_SH  = M_LH;
  localparam logic [2:0] M_SW  = M_LW;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    FAULT
  } lsu_state_e;

  // Misaligned accesses, unused encodings and stores of unsigned ops all fault.
  function automatic logic lsu_fault(input logic [2:0] op, input logic we, input logic [1:0] off);
    logic f;
    case (op)
      M_LB:    f = 1'b0;
      M_LH:    f = off[0];
      M_LW:    f = (off != 2'b00);
      M_LBU:   f = we;
      M_LHU:   f = we | off[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lsu_wmask(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] m;
    case (op)
      M_SB:    m = 4'b0001 << off;
      M_SH:    m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// rtl/lsu_load_extract.sv - Selects the addressed byte/half/word from a read word and extends it.
module lsu_load_extract
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] lane;

  always_comb begin
    lane = word_i >> {off_i, 3'b000};
    case (op_i)
      M_LB:    result_o = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      M_LH:    result_o = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      M_LW:    result_o = lane;
      M_LBU:   result_o = {{(DATA_W-8){1'b0}}, lane[7:0]};
      M_LHU:   result_o = {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - Single-outstanding load/store initiator driving a word-wide data-memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  input  logic [2:0]        reqMemOp,
  input  logic              reqWe,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              rspFault,
  output logic              memReqValid,
  input  logic              memReqReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic [3:0]        memWmask,
  output logic              memWe,
  input  logic              memRspValid,
  input  logic [DATA_W-1:0] memRdata
);

  lsu_state_e        state_q;
  logic [1:0]        off_q;
  logic [2:0]        op_q;
  logic              reqReady_q;
  logic              rspValid_q;
  logic [DATA_W-1:0] rspData_q;
  logic              rspFault_q;
  logic              memReqValid_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic [3:0]        memWmask_q;
  logic              memWe_q;

  logic [1:0]        req_off;
  logic              req_fault;
  logic [DATA_W-1:0] load_result;

  assign req_off   = reqAddr[1:0];
  assign req_fault = lsu_fault(reqMemOp, reqWe, req_off);

  lsu_load_extract #(.DATA_W(DATA_W)) u_extract (
    .word_i  (memRdata),
    .off_i   (off_q),
    .op_i    (op_q),
    .result_o(load_result)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      off_q         <= 2'b00;
      op_q          <= 3'b000;
      reqReady_q    <= 1'b0;
      rspValid_q    <= 1'b0;
      rspData_q     <= '0;
      rspFault_q    <= 1'b0;
      memReqValid_q <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      memWmask_q    <= 4'b0000;
      memWe_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // reqReady_q is low for the first IDLE cycle out of reset, so nothing is accepted then.
          if (reqReady_q && reqValid) begin
            reqReady_q <= 1'b0;
            off_q      <= req_off;
            op_q       <= reqMemOp;
            if (req_fault) begin
              state_q    <= FAULT;
              rspValid_q <= 1'b1;
              rspFault_q <= 1'b1;
            end else begin
              state_q       <= ISSUE;
              memReqValid_q <= 1'b1;
              memAddr_q     <= {reqAddr[ADDR_W-1:2], 2'b00};
              memWe_q       <= reqWe;
              memWmask_q    <= reqWe ? lsu_wmask(reqMemOp, req_off) : 4'b0000;
              memWdata_q    <= reqWe ? (reqWdata << {req_off, 3'b000}) : '0;
            end
          end else begin
            reqReady_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (memReqReady) begin
            memReqValid_q <= 1'b0;
            if (memWe_q) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (memRspValid) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
            rspData_q  <= load_result;
          end
        end
        RESP, FAULT: begin
          state_q    <= IDLE;
          rspValid_q <= 1'b0;
          rspFault_q <= 1'b0;
          rspData_q  <= '0;
          reqReady_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqReady    = reqReady_q;
  assign rspValid    = rspValid_q;
  assign rspData     = rspData_q;
  assign rspFault    = rspFault_q;
  assign memReqValid = memReqValid_q;
  assign memAddr     = memAddr_q;
  assign memWdata    = memWdata_q;
  assign memWmask    = memWmask_q;
  assign memWe       = memWe_q;

endmodule
